range_window_monitor: RTL and testbench

RANGE_WINDOW_MONITOR -- requirements
Module: range_window_monitor

---
 rtl/range_window_monitor.sv | 143 ++++++++++++++
 tb/tb_range_window_monitor.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/range_window_monitor.sv
// Tracks a wrapping count against a programmable inclusive window, strobing on crossings and wraps.
// Optional discontinuity checker enabled by defining RANGE_MON_JUMP_CHECK_EN.
module range_window_monitor #(
    parameter int WIDTH  = 6,
    parameter int LAP_W  = 8,
    parameter int DEF_LO = 10,
    parameter int DEF_HI = 50
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] count_in,
    input  logic             count_valid,
    input  logic             cfg_load,
    input  logic [WIDTH-1:0] win_lo,
    input  logic [WIDTH-1:0] win_hi,
    output logic             in_window,
    output logic             enter_pulse,
    output logic             exit_pulse,
    output logic             wrap_pulse,
    output logic [LAP_W-1:0] lap_count,
    output logic             lap_sat,
    output logic             cfg_err,
    output logic             jump_err
);

    typedef enum logic [1:0] {IDLE, OUTSIDE, INSIDE} state_e;

    localparam logic [WIDTH-1:0] LO_RST  = WIDTH'(DEF_LO);
    localparam logic [WIDTH-1:0] HI_RST  = WIDTH'(DEF_HI);
    localparam logic             ERR_RST = (DEF_LO > DEF_HI);
    localparam logic [LAP_W-1:0] LAP_MAX = {LAP_W{1'b1}};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d, prev_q, prev_d;
    logic             in_window_q, in_window_d;
    logic             enter_q, enter_d, exit_q, exit_d, wrap_q, wrap_d;
    logic [LAP_W-1:0] lap_q, lap_d;
    logic             lap_sat_q, lap_sat_d, cfg_err_q, cfg_err_d;
    logic             sample_in, is_wrap;

    // The sample is judged against the window active before any same-cycle load.
    assign sample_in = (count_in >= lo_q) && (count_in <= hi_q);
    assign is_wrap   = (state_q != IDLE) && (count_in < prev_q);

    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        prev_d      = prev_q;
        in_window_d = in_window_q;
        enter_d     = 1'b0;
        exit_d      = 1'b0;
        wrap_d      = 1'b0;
        lap_d       = lap_q;
        lap_sat_d   = lap_sat_q;
        cfg_err_d   = cfg_err_q;

        if (cfg_load) begin
            lo_d      = win_lo;
            hi_d      = win_hi;
            cfg_err_d = (win_lo > win_hi);
        end

        if (count_valid) begin
            state_d     = sample_in ? INSIDE : OUTSIDE;
            in_window_d = sample_in;
            prev_d      = count_in;
            enter_d     = (state_q == OUTSIDE) && sample_in;
            exit_d      = (state_q == INSIDE) && !sample_in;
            if (is_wrap) begin
                wrap_d = 1'b1;
                if (lap_q != LAP_MAX) begin
                    lap_d = lap_q + LAP_W'(1);
                end
                if (lap_q >= LAP_MAX - LAP_W'(1)) begin
                    lap_sat_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            lo_q        <= LO_RST;
            hi_q        <= HI_RST;
            prev_q      <= '0;
            in_window_q <= 1'b0;
            enter_q     <= 1'b0;
            exit_q      <= 1'b0;
            wrap_q      <= 1'b0;
            lap_q       <= '0;
            lap_sat_q   <= 1'b0;
            cfg_err_q   <= ERR_RST;
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            prev_q      <= prev_d;
            in_window_q <= in_window_d;
            enter_q     <= enter_d;
            exit_q      <= exit_d;
            wrap_q      <= wrap_d;
            lap_q       <= lap_d;
            lap_sat_q   <= lap_sat_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

`ifdef RANGE_MON_JUMP_CHECK_EN
    logic jump_q, jump_d;

    // A legal step is +1 or a wrap downwards; anything else latches the flag.
    always_comb begin
        jump_d = jump_q;
        if (count_valid && (state_q != IDLE) &&
            (count_in != prev_q + WIDTH'(1)) && !(count_in < prev_q)) begin
            jump_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            jump_q <= 1'b0;
        end else begin
            jump_q <= jump_d;
        end
    end

    assign jump_err = jump_q;
`else
    assign jump_err = 1'b0;
`endif

    assign in_window   = in_window_q;
    assign enter_pulse = enter_q;
    assign exit_pulse  = exit_q;
    assign wrap_pulse  = wrap_q;
    assign lap_count   = lap_q;
    assign lap_sat     = lap_sat_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_range_window_monitor.sv
// Directed bench for range_window_monitor: vector table plus hand sequences for reset, laps and jumps.
module tb_range_window_monitor;

`ifdef RANGE_MON_JUMP_CHECK_EN
    localparam bit JMP = 1'b1;
`else
    localparam bit JMP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] count_in = '0;
    logic       count_valid = 1'b0;
    logic       cfg_load = 1'b0;
    logic [5:0] win_lo = '0;
    logic [5:0] win_hi = '0;

    logic       in_window, enter_pulse, exit_pulse, wrap_pulse, lap_sat, cfg_err, jump_err;
    logic [7:0] lap_count;
    logic       in_window2, enter_pulse2, exit_pulse2, wrap_pulse2, lap_sat2, cfg_err2, jump_err2;
    logic [1:0] lap_count2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    range_window_monitor dut (
        .clk(clk), .rst(rst), .count_in(count_in), .count_valid(count_valid),
        .cfg_load(cfg_load), .win_lo(win_lo), .win_hi(win_hi),
        .in_window(in_window), .enter_pulse(enter_pulse), .exit_pulse(exit_pulse),
        .wrap_pulse(wrap_pulse), .lap_count(lap_count), .lap_sat(lap_sat),
        .cfg_err(cfg_err), .jump_err(jump_err)
    );

    range_window_monitor #(.LAP_W(2)) dut2 (
        .clk(clk), .rst(rst), .count_in(count_in), .count_valid(count_valid),
        .cfg_load(cfg_load), .win_lo(win_lo), .win_hi(win_hi),
        .in_window(in_window2), .enter_pulse(enter_pulse2), .exit_pulse(exit_pulse2),
        .wrap_pulse(wrap_pulse2), .lap_count(lap_count2), .lap_sat(lap_sat2),
        .cfg_err(cfg_err2), .jump_err(jump_err2)
    );

    typedef struct {
        logic       v;
        logic [5:0] cnt;
        logic       ld;
        logic [5:0] lo;
        logic [5:0] hi;
        logic       inw;
        logic       en;
        logic       ex;
        logic       wr;
        logic [7:0] lap;
        logic       cerr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input int cnt, input logic ld, input int lo, input int hi,
                       input logic inw, input logic en, input logic ex, input logic wr,
                       input int lap, input logic cerr);
        vec_t t;
        t.v = v; t.cnt = 6'(cnt); t.ld = ld; t.lo = 6'(lo); t.hi = 6'(hi);
        t.inw = inw; t.en = en; t.ex = ex; t.wr = wr; t.lap = 8'(lap); t.cerr = cerr;
        vecs.push_back(t);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic v, input int cnt, input logic ld, input int lo, input int hi);
        @(negedge clk);
        count_valid = v;
        count_in    = 6'(cnt);
        cfg_load    = ld;
        win_lo      = 6'(lo);
        win_hi      = 6'(hi);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        count_valid = 1'b0;
        cfg_load    = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " in_window"}, in_window, 0);
        chk({tag, " enter"}, enter_pulse, 0);
        chk({tag, " exit"}, exit_pulse, 0);
        chk({tag, " wrap"}, wrap_pulse, 0);
        chk({tag, " lap"}, lap_count, 0);
        chk({tag, " lap_sat"}, lap_sat, 0);
        chk({tag, " cfg_err"}, cfg_err, 0);
        chk({tag, " jump_err"}, jump_err, 0);
    endtask

    initial begin
        //   v  cnt ld lo hi   inw en ex wr lap cerr
        add(1,  8, 0, 0, 0,    0, 0, 0, 0, 0, 0);
        add(1,  9, 0, 0, 0,    0, 0, 0, 0, 0, 0);
        add(1, 10, 0, 0, 0,    1, 1, 0, 0, 0, 0);
        add(1, 11, 0, 0, 0,    1, 0, 0, 0, 0, 0);
        add(0,  0, 0, 0, 0,    1, 0, 0, 0, 0, 0);
        add(1, 49, 0, 0, 0,    1, 0, 0, 0, 0, 0);
        add(1, 50, 0, 0, 0,    1, 0, 0, 0, 0, 0);
        add(1, 51, 0, 0, 0,    0, 0, 1, 0, 0, 0);
        add(1, 63, 0, 0, 0,    0, 0, 0, 0, 0, 0);
        add(1,  0, 0, 0, 0,    0, 0, 0, 1, 1, 0);
        add(1, 10, 0, 0, 0,    1, 1, 0, 0, 1, 0);
        add(1,  5, 0, 0, 0,    0, 0, 1, 1, 2, 0);
        add(1, 15, 1, 20, 30,  1, 1, 0, 0, 2, 0);
        add(1, 16, 0, 0, 0,    0, 0, 1, 0, 2, 0);
        add(1, 25, 0, 0, 0,    1, 1, 0, 0, 2, 0);
        add(0,  0, 1, 40, 5,   1, 0, 0, 0, 2, 1);
        add(1, 26, 0, 0, 0,    0, 0, 1, 0, 2, 1);

        #2;
        chk_reset_vals("rst0");
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].v, int'(vecs[i].cnt), vecs[i].ld, int'(vecs[i].lo), int'(vecs[i].hi));
            chk($sformatf("v%0d in_window", i), in_window, vecs[i].inw);
            chk($sformatf("v%0d enter", i), enter_pulse, vecs[i].en);
            chk($sformatf("v%0d exit", i), exit_pulse, vecs[i].ex);
            chk($sformatf("v%0d wrap", i), wrap_pulse, vecs[i].wr);
            chk($sformatf("v%0d lap", i), lap_count, vecs[i].lap);
            chk($sformatf("v%0d cfg_err", i), cfg_err, vecs[i].cerr);
        end

        // Empty window: a full sweep never enters.
        for (int c = 0; c < 64; c++) begin
            step(1'b1, c, 1'b0, 0, 0);
            chk($sformatf("sweep%0d in_window", c), in_window, 0);
            chk($sformatf("sweep%0d enter", c), enter_pulse, 0);
        end
        chk("sweep lap", lap_count, 3);
        chk("sweep cfg_err", cfg_err, 1);

        step(1'b0, 0, 1'b1, 10, 50);
        chk("reload cfg_err", cfg_err, 0);
        chk("reload in_window", in_window, 0);
        chk("reload enter", enter_pulse, 0);

        step(1'b1, 30, 1'b0, 0, 0);
        chk("s30 enter", enter_pulse, 1);
        chk("s30 wrap", wrap_pulse, 1);
        chk("s30 lap", lap_count, 4);
        chk("s30 in_window", in_window, 1);

        // Asynchronous reset mid-cycle while pulses are high.
        @(negedge clk);
        count_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        rst = 1'b1;

        step(1'b1, 30, 1'b0, 0, 0);
        chk("idle30 in_window", in_window, 1);
        chk("idle30 enter", enter_pulse, 0);
        chk("idle30 wrap", wrap_pulse, 0);
        step(1'b1, 20, 1'b0, 0, 0);
        chk("s20 wrap", wrap_pulse, 1);
        chk("s20 lap", lap_count, 1);
        chk("s20 exit", exit_pulse, 0);

        // Discontinuity check.
        do_reset();
        step(1'b1, 5, 1'b0, 0, 0);
        chk("j5 jump_err", jump_err, 0);
        step(1'b1, 6, 1'b0, 0, 0);
        chk("j6 jump_err", jump_err, 0);
        step(1'b1, 9, 1'b0, 0, 0);
        chk("j9 jump_err", jump_err, int'(JMP));
        step(1'b1, 10, 1'b0, 0, 0);
        chk("j10 jump_err", jump_err, int'(JMP));
        @(negedge clk);
        count_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk_reset_vals("jrst");
        @(negedge clk);
        rst = 1'b1;

        // Lap saturation on the narrow instance.
        step(1'b1, 1, 1'b0, 0, 0);
        chk("l0 wrap", wrap_pulse2, 0);
        for (int w = 1; w <= 4; w++) begin
            step(1'b1, 0, 1'b0, 0, 0);
            chk($sformatf("lap%0d wrap", w), wrap_pulse2, 1);
            chk($sformatf("lap%0d count", w), lap_count2, (w < 3) ? w : 3);
            chk($sformatf("lap%0d sat", w), lap_sat2, (w >= 3) ? 1 : 0);
            step(1'b1, 1, 1'b0, 0, 0);
            chk($sformatf("lap%0d nowrap", w), wrap_pulse2, 0);
        end
        chk("wide lap", lap_count, 4);
        chk("wide sat", lap_sat, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
